// File: rtl/audio_channel_out_if.sv
// +----------------------------------------------------------------------------+
// | audio_channel_out_if                                                       |
// | Per-channel audio stage bus: timer borrows, AUDC write, poly taps, outputs |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface audio_channel_out_if;
   logic       enn;
   logic [7:0] d;
   logic       wr;
   logic       nBor;
   logic       hpBor;
   logic       hpEn;
   logic       initMode;
   logic       poly4;
   logic       poly5;
   logic       poly17;
   logic       chOut;
   logic [3:0] volOut;

   modport master (
      output enn, d, wr, nBor, hpBor, hpEn, initMode, poly4, poly5, poly17,
      input  chOut, volOut
   );

   modport slave (
      input  enn, d, wr, nBor, hpBor, hpEn, initMode, poly4, poly5, poly17,
      output chOut, volOut
   );
endinterface

`default_nettype wire

// File: rtl/audio_channel_out.sv
// +----------------------------------------------------------------------------+
// | audio_channel_out                                                          |
// | Turns timer underflows into the channel waveform and mixer volume sample.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module audio_channel_out (
   input  wire logic           clk,
   input  wire logic           nRst,
   audio_channel_out_if.slave  bus
);

   localparam logic [3:0] c_VOL_SILENT = 4'h0;

   logic [7:0] r_audc;
   logic       r_tone;
   logic       r_hp;
   logic [3:0] r_vol;

   logic       w_evt;
   logic       w_hpEvt;
   logic       w_gate;
   logic       w_toneNext;
   logic       w_chOut;
   logic [3:0] w_volNext;

   assign w_evt   = bus.enn & ~bus.nBor;
   assign w_hpEvt = bus.enn & ~bus.hpBor;
   assign w_gate  = r_audc[7] | bus.poly5;

   always_comb begin
      w_toneNext = r_tone;
      if (w_evt && w_gate) begin
         if (r_audc[5])
            w_toneNext = ~r_tone;
         else
            w_toneNext = r_audc[6] ? bus.poly4 : bus.poly17;
      end
   end

   assign w_chOut   = bus.hpEn ? (r_tone ^ r_hp) : r_tone;
   assign w_volNext = (r_audc[4] || w_chOut) ? r_audc[3:0] : c_VOL_SILENT;

   // All state is clocked on the falling edge; AUDC updates after evt reads it.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         r_audc <= 8'h00;
         r_tone <= 1'b0;
         r_hp   <= 1'b0;
         r_vol  <= c_VOL_SILENT;
      end else begin
         if (bus.wr)
            r_audc <= bus.d;
         r_vol <= w_volNext;
         if (bus.initMode) begin
            r_tone <= 1'b0;
            r_hp   <= 1'b0;
         end else begin
            r_tone <= w_toneNext;
            if (w_hpEvt)
               r_hp <= r_tone;
         end
      end
   end

   assign bus.chOut  = w_chOut;
   assign bus.volOut = r_vol;

endmodule

`default_nettype wire

// File: tb/tb_audio_channel_out.sv
// +----------------------------------------------------------------------------+
// | tb_audio_channel_out                                                       |
// | Directed self-checking bench for audio_channel_out.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_audio_channel_out;

   logic clk;
   logic nRst;
   int   total;
   int   bad;

   audio_channel_out_if bus ();

   audio_channel_out dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the active (falling) edge; outputs are sampled there too.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] vol();
      return {4'h0, bus.volOut};
   endfunction

   function automatic logic [7:0] ch();
      return {7'h0, bus.chOut};
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      nRst  = 1'b1;
      bus.enn = 1'b0; bus.d = 8'h00; bus.wr = 1'b0;
      bus.nBor = 1'b1; bus.hpBor = 1'b1; bus.hpEn = 1'b0; bus.initMode = 1'b0;
      bus.poly4 = 1'b0; bus.poly5 = 1'b0; bus.poly17 = 1'b0;

      #2 nRst = 1'b0;
      #1;
      chk("rst_vol", vol(), 8'h00);
      chk("rst_ch",  ch(),  8'h00);
      #3 nRst = 1'b1;

      // Pure tone, volume 8
      bus.d = 8'hA8; bus.wr = 1'b1;
      tick();
      chk("wr_vol_old", vol(), 8'h00);
      bus.wr = 1'b0; bus.enn = 1'b1;
      bus.nBor = 1'b0; tick();
      chk("tone_up_ch",  ch(),  8'h01);
      chk("tone_up_lag", vol(), 8'h00);
      bus.nBor = 1'b1; tick();
      chk("tone_up_vol", vol(), 8'h08);
      chk("tone_hold",   ch(),  8'h01);
      tick(); tick();
      bus.nBor = 1'b0; tick();
      chk("tone_dn_ch",  ch(),  8'h00);
      chk("tone_dn_lag", vol(), 8'h08);
      bus.nBor = 1'b1; tick();
      chk("tone_dn_vol", vol(), 8'h00);

      // Volume-only
      bus.d = 8'h1F; bus.wr = 1'b1; tick();
      bus.wr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.nBor   = i[0];
         bus.poly5  = i[1];
         bus.poly17 = ~i[0];
         tick();
         chk("volonly_F", vol(), 8'h0F);
      end
      bus.nBor = 1'b1;
      bus.d = 8'h15; bus.wr = 1'b1; tick();
      chk("volonly_wr_edge", vol(), 8'h0F);
      bus.wr = 1'b0; tick();
      chk("volonly_5", vol(), 8'h05);

      // Poly5-gated pure tone
      bus.d = 8'h28; bus.wr = 1'b1; bus.initMode = 1'b1; tick();
      bus.wr = 1'b0; bus.initMode = 1'b0;
      bus.nBor = 1'b0; bus.poly5 = 1'b0; tick();
      chk("gate_closed", ch(), 8'h00);
      bus.poly5 = 1'b1; tick();
      chk("gate_open", ch(), 8'h01);
      bus.nBor = 1'b1; tick();
      chk("gate_vol", vol(), 8'h08);

      // Poly4 noise source
      bus.d = 8'h48; bus.wr = 1'b1; bus.initMode = 1'b1; tick();
      bus.wr = 1'b0; bus.initMode = 1'b0;
      bus.nBor = 1'b0; bus.poly4 = 1'b1; bus.poly17 = 1'b0; tick();
      chk("poly4_one", ch(), 8'h01);
      bus.poly4 = 1'b0; bus.poly17 = 1'b1; tick();
      chk("poly4_zero", ch(), 8'h00);
      bus.nBor = 1'b1;

      // High-pass
      bus.d = 8'hA4; bus.wr = 1'b1; bus.initMode = 1'b1; tick();
      bus.wr = 1'b0; bus.initMode = 1'b0; bus.hpEn = 1'b1;
      bus.nBor = 1'b0; bus.hpBor = 1'b0; tick();
      chk("hp_same_edge", ch(), 8'h01);
      bus.nBor = 1'b1; tick();
      chk("hp_alone", ch(), 8'h00);
      bus.hpBor = 1'b1; bus.hpEn = 1'b0; #1;
      chk("hp_bypass", ch(), 8'h01);

      // Enable gating with nBor held low
      bus.d = 8'hA2; bus.wr = 1'b1; bus.initMode = 1'b1; tick();
      bus.wr = 1'b0; bus.initMode = 1'b0; bus.nBor = 1'b0;
      bus.enn = 1'b1; tick(); chk("enn_e1", ch(), 8'h01);
      bus.enn = 1'b0; tick(); chk("enn_e2", ch(), 8'h01);
      bus.enn = 1'b1; tick(); chk("enn_e3", ch(), 8'h00);
      bus.enn = 1'b0; tick(); chk("enn_e4", ch(), 8'h00);
      bus.enn = 1'b1; tick(); chk("enn_e5", ch(), 8'h01);

      // Write coinciding with evt: old AUDC (A2) used, new (22, poly5-gated) afterwards
      bus.poly5 = 1'b0;
      tick(); chk("wr_evt_pre", ch(), 8'h00);
      bus.d = 8'h22; bus.wr = 1'b1; tick();
      chk("wr_evt_old", ch(), 8'h01);
      bus.wr = 1'b0; tick();
      chk("wr_evt_new", ch(), 8'h01);

      // initMode while toggling
      bus.nBor = 1'b1;
      bus.d = 8'hAA; bus.wr = 1'b1; tick();
      bus.wr = 1'b0; bus.nBor = 1'b0; bus.hpBor = 1'b0; bus.hpEn = 1'b1;
      tick();
      chk("hp_toggle1", ch(), 8'h01);
      tick();
      chk("hp_toggle2", ch(), 8'h01);
      bus.initMode = 1'b1; tick();
      chk("init_ch_hp", ch(), 8'h00);
      bus.hpEn = 1'b0; #1;
      chk("init_tone", ch(), 8'h00);
      bus.nBor = 1'b1; bus.hpBor = 1'b1;
      bus.d = 8'h1F; bus.wr = 1'b1; tick();
      bus.wr = 1'b0; tick();
      chk("init_volonly", vol(), 8'h0F);

      // Asynchronous reset mid-run
      #2 nRst = 1'b0;
      #1;
      chk("arst_vol", vol(), 8'h00);
      chk("arst_ch",  ch(),  8'h00);
      #1 nRst = 1'b1;
      bus.initMode = 1'b0; bus.enn = 1'b0;
      tick();
      chk("arst_audc", vol(), 8'h00);
      bus.d = 8'hA8; bus.wr = 1'b1; tick();
      bus.wr = 1'b0; bus.enn = 1'b1; bus.nBor = 1'b0; tick();
      chk("post_rst_tone", ch(), 8'h01);
      bus.nBor = 1'b1; tick();
      chk("post_rst_vol", vol(), 8'h08);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/audio_channel_out.md
Name: audio_channel_out

Overview:
- Downstream stage of the 8-bit channel timer: consumes the timer's active-low borrow (`nBor`) and turns each underflow into the channel's audio waveform.
- Holds the channel control register (AUDC): distortion select, volume-only flag and 4-bit volume.
- Gates and selects the shared poly-counter bits, runs the optional high-pass flip-flop, and produces the registered 4-bit volume sample that goes to the mixer.

Parameters:
- none (all widths fixed by the POKEY register map)

Ports:
- clk  input  1  system clock; all state updates on the falling edge
- nRst  input  1  asynchronous active-low reset
- enn  input  1  clock enable, same enable that drives the channel timer; events sampled only when 1
- d  input  8  CPU data bus
- wr  input  1  AUDC write strobe for this channel
- nBor  input  1  active-low underflow from this channel's timer
- hpBor  input  1  active-low underflow from the high-pass clocking channel's timer
- hpEn  input  1  high-pass filter enable for this channel (from AUDCTL)
- initMode  input  1  serial init/reset mode; holds the channel quiet
- poly4  input  1  current output bit of the shared 4-bit poly counter
- poly5  input  1  current output bit of the shared 5-bit poly counter
- poly17  input  1  current output bit of the shared 17/9-bit poly counter
- chOut  output  1  digital waveform after the high-pass stage
- volOut  output  4  registered volume sample to the mixer

Behaviour:
- Reset (nRst = 0, asynchronous): AUDC = 8'h00, tone FF = 0, hpFF = 0, volOut = 4'h0. chOut is therefore 0.
- AUDC write:
  - On a falling edge with wr = 1, AUDC <= d, independent of enn.
  - Field meanings: [7] = 0 gates with poly5; [6] selects noise source (1 = poly4, 0 = poly17); [5] = 1 selects pure tone; [4] = volume-only; [3:0] = volume.
- Channel event (`evt`): a falling edge with enn = 1 and nBor = 0. No edge detection is applied; each qualifying edge is one event.
- On `evt`:
  - gate = AUDC[7] ? 1 : poly5.
  - If gate = 1: when AUDC[5] = 1, tone <= ~tone; otherwise tone <= AUDC[6] ? poly4 : poly17.
  - If gate = 0: tone holds.
- High-pass: on a falling edge with enn = 1 and hpBor = 0, hpFF <= tone. The sampled value is the pre-update tone when that edge is also an `evt`.
- chOut (combinational): hpEn ? (tone ^ hpFF) : tone.
- volOut (registered, one falling edge after the chOut change): AUDC[4] ? AUDC[3:0] : (chOut ? AUDC[3:0] : 4'h0). Updates every falling edge regardless of enn.
- initMode = 1 (synchronous): tone <= 0 and hpFF <= 0 on every falling edge, overriding `evt` and hpBor. AUDC writes and volOut still operate, so a volume-only sample remains audible.
- Simultaneous write and `evt`: `evt` uses the old AUDC; the new AUDC takes effect from the next edge. volOut on that same edge is computed from the old AUDC.
- enn = 0: nBor and hpBor are ignored and tone/hpFF hold, even while nBor stays low.
- Reset mid-waveform: all state clears immediately. The first `evt` after reset with pure tone drives tone to 1.
- The poly inputs are sampled only on `evt` edges; no internal poly state is kept.

Test Plan:
- Reset, then write AUDC = 8'hA8 (pure tone, vol 8), enn = 1, pulse nBor low for 1 cycle every 4 cycles -> chOut toggles on each pulse; volOut alternates 4'h8 / 4'h0, lagging chOut by one edge.
- AUDC = 8'h1F (volume-only, vol F), random nBor/poly activity -> volOut constantly 4'hF. Switch to 8'h15 -> volOut = 4'h5 one edge after the write.
- AUDC = 8'h28 (poly5 gated, pure tone), poly5 = 0 on first `evt` and 1 on second -> tone unchanged after the first event, toggled after the second. AUDC = 8'h48 with poly4 = 1 -> tone = 1 after `evt`.
- hpEn = 1, AUDC = 8'hA4, nBor and hpBor pulsed on the same edge with tone = 0 -> hpFF = 0, tone = 1, chOut = 1. hpBor alone on the next edge -> hpFF = 1, chOut = 0.
- nBor held low for 5 edges with enn = 1,0,1,0,1 and AUDC = 8'hA2 -> exactly 3 toggles. Write AUDC on the third of those edges -> that event still uses the old value.
- initMode = 1 while toggling -> tone = hpFF = 0 with chOut = 0 within one edge. Assert nRst low mid-run -> volOut = 4'h0 and AUDC = 8'h00 without waiting for a clock edge.
